// File: rtl/matrix_mul_tiled.sv
// Tiled signed SxS matrix multiply (C = A*B or C += A*B), S <= N, operands loaded row-major A then B.
// Latency: last B beat to first output is S*S+3 cycles (S*S issue + 3-stage multiply/add/accumulate pipe).
// Backpressure: in_ready only in load states; out_data holds stable while out_ready is low.
module matrix_mul_tiled #(
  parameter int N         = 4,
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 32,
  parameter int ACC_GUARD = 4,
  localparam int LN       = $clog2(N),
  localparam int ACC_W    = 2*DATA_W + LN + ACC_GUARD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LN:0]       size,
  input  logic              acc_en,
  input  logic              sat_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DRAIN, OUT, DONE} state_t;
  state_t state, state_nxt;

  logic [LN:0]   s_lat;
  logic [LN:0]   size_eff;
  logic          acc_lat, sat_lat;
  logic [LN-1:0] row, col, s_max;
  logic          last_elem, adv, drain_cnt;

  logic signed [DATA_W-1:0]   a_m [N][N];
  logic signed [DATA_W-1:0]   b_m [N][N];
  logic signed [ACC_W-1:0]    c_m [N][N];
  logic signed [2*DATA_W-1:0] prod [N];
  logic signed [ACC_W-1:0]    sum_c, s2_sum, c_sel;
  logic                       s1_vld, s2_vld;
  logic [LN-1:0]              s1_row, s1_col, s2_row, s2_col;
  logic [ACC_W-OUT_W:0]       hi;

  assign size_eff  = (size == '0 || size > (LN+1)'(N)) ? (LN+1)'(N) : size;
  assign s_max     = LN'(s_lat - 1'b1);
  assign last_elem = (row == s_max) && (col == s_max);
  assign adv       = (in_valid && in_ready) || (state == CALC) || (out_valid && out_ready);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = LOAD_A;
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && last_elem) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && last_elem) state_nxt = CALC;
      end
      CALC:   if (last_elem) state_nxt = DRAIN;
      DRAIN:  if (drain_cnt) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready && last_elem) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Adder tree over the registered products, each sign-extended to the accumulator width
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N; k++) sum_c = sum_c + ACC_W'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_lat     <= '0;
      acc_lat   <= 1'b0;
      sat_lat   <= 1'b0;
      row       <= '0;
      col       <= '0;
      drain_cnt <= 1'b0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s2_row    <= '0;
      s2_col    <= '0;
      s2_sum    <= '0;
      for (int i = 0; i < N; i++) begin
        prod[i] <= '0;
        for (int j = 0; j < N; j++) begin
          a_m[i][j] <= '0;
          b_m[i][j] <= '0;
          c_m[i][j] <= '0;
        end
      end
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;

      if (state == IDLE && start) begin
        s_lat   <= size_eff;
        acc_lat <= acc_en;
        sat_lat <= sat_en;
        row     <= '0;
        col     <= '0;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            a_m[i][j] <= '0;
            b_m[i][j] <= '0;
            if (!acc_en) c_m[i][j] <= '0;
          end
        end
      end else if (adv) begin
        if (last_elem) begin
          row <= '0;
          col <= '0;
        end else if (col == s_max) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (in_valid && in_ready) begin
        if (state == LOAD_A) a_m[row][col] <= in_data;
        else                 b_m[row][col] <= in_data;
      end

      s1_vld <= (state == CALC);
      s1_row <= row;
      s1_col <= col;
      for (int k = 0; k < N; k++)
        prod[k] <= (2*DATA_W)'(a_m[row][k]) * (2*DATA_W)'(b_m[k][col]);

      s2_vld <= s1_vld;
      s2_row <= s1_row;
      s2_col <= s1_col;
      s2_sum <= sum_c;

      if (s2_vld) c_m[s2_row][s2_col] <= c_m[s2_row][s2_col] + s2_sum;
    end
  end

  // Saturate when the bits above the output sign bit are not a pure sign extension
  always_comb begin
    c_sel = c_m[row][col];
    hi    = c_sel[ACC_W-1:OUT_W-1];
    if (state != OUT)
      out_data = '0;
    else if (sat_lat && !((&hi) || (~|hi)))
      out_data = c_sel[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      out_data = c_sel[OUT_W-1:0];
  end

endmodule

// File: tb/tb_matrix_mul_tiled.sv
// Directed bench for matrix_mul_tiled (N=4, 16-bit operands, 16-bit output) with a product model and scoreboard.
module tb_matrix_mul_tiled;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  size = '0;
  logic        acc_en = 1'b0;
  logic        sat_en = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  matrix_mul_tiled #(.N(4), .DATA_W(16), .OUT_W(16), .ACC_GUARD(4)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .acc_en(acc_en), .sat_en(sat_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  int     first_ov = -1;
  bit     gap_out = 1'b0;
  int     a_v [16];
  int     b_v [16];
  longint mc [4][4];
  int     exp_q [$];
  int     got [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accumulator is 38 bits wide; model keeps it in a longint and wraps explicitly
  function automatic longint wrap38(input longint v);
    longint w;
    w = v <<< 26;
    return w >>> 26;
  endfunction

  function automatic int conv(input longint v, input bit sat);
    shortint t;
    if (sat) begin
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
    end
    t = shortint'(v);
    return int'(t);
  endfunction

  function automatic int gv(input int k);
    return (got.size() > k) ? got[k] : -99999;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = gap_out ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard: every output handshake against the model, plus hold-while-stalled
  initial begin
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    int          v;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (out_valid && first_ov < 0) first_ov = cyc + 1;
      if (prev_stall) chk("out_hold", longint'(out_data), longint'(prev_data));
      if (out_valid && out_ready) begin
        v = int'($signed(out_data));
        got.push_back(v);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_out: got %0d expected no element", v);
        end else begin
          chk("out_elem", v, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic session(input int s, input bit acc, input bit sat, input bit gin, input bit gout,
                         input bit abort_calc, input bit start_in_out);
    int     ss, idx, tmo, last_b;
    bit     hs, pulsed;
    longint sum;
    ss = s * s;
    if (!acc) foreach (mc[i, j]) mc[i][j] = 0;
    if (!abort_calc) begin
      for (int i = 0; i < s; i++)
        for (int j = 0; j < s; j++) begin
          sum = 0;
          for (int k = 0; k < s; k++) sum += longint'(a_v[i*s+k]) * longint'(b_v[k*s+j]);
          mc[i][j] = wrap38(mc[i][j] + sum);
          exp_q.push_back(conv(mc[i][j], sat));
        end
    end
    got.delete();
    done_cnt = 0;
    first_ov = -1;
    gap_out  = gout;
    @(posedge clk); #1;
    size = 3'(s); acc_en = acc; sat_en = sat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; tmo = 0; last_b = 0;
    while (idx < 2*ss && tmo < 2000) begin
      in_valid = gin ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (idx < ss) ? 16'(a_v[idx]) : 16'(b_v[idx-ss]);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      tmo++;
      if (hs) begin
        idx++;
        if (idx == 2*ss) last_b = cyc;
      end
    end
    in_valid = 1'b0;
    chk("load_beats", idx, 2*ss);
    @(negedge clk);
    chk("in_ready_after_load", in_ready, 0);
    if (abort_calc) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      foreach (mc[i, j]) mc[i][j] = 0;
    end else begin
      tmo = 0; pulsed = 1'b0;
      while (done_cnt == 0 && tmo < 3000) begin
        @(negedge clk);
        tmo++;
        if (start_in_out && !pulsed && out_valid) begin
          start  = 1'b1;
          pulsed = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      chk("done_seen", done_cnt > 0, 1);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("exp_drained", exp_q.size(), 0);
      chk("out_count", got.size(), ss);
      chk("idle_after", busy, 0);
      if (!gin && !gout) chk("latency", first_ov - last_b, ss + 3);
    end
    exp_q.delete();
    gap_out = 1'b0;
  endtask

  task automatic set2(input int a0, a1, a2, a3, b0, b1, b2, b3);
    a_v[0] = a0; a_v[1] = a1; a_v[2] = a2; a_v[3] = a3;
    b_v[0] = b0; b_v[1] = b1; b_v[2] = b2; b_v[3] = b3;
  endtask

  initial begin
    foreach (mc[i, j]) mc[i][j] = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity times 1..16
    for (int i = 0; i < 16; i++) begin
      a_v[i] = (i / 4 == i % 4) ? 1 : 0;
      b_v[i] = i + 1;
    end
    session(4, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) chk("ident_lit", gv(k), k + 1);

    // Reduced size, then accumulate, then clear again
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    session(2, 0, 0, 0, 0, 0, 0);
    chk("s2_lit0", gv(0), 19); chk("s2_lit1", gv(1), 22);
    chk("s2_lit2", gv(2), 43); chk("s2_lit3", gv(3), 50);
    session(2, 1, 0, 0, 0, 0, 0);
    chk("acc_lit0", gv(0), 38); chk("acc_lit1", gv(1), 44);
    chk("acc_lit2", gv(2), 86); chk("acc_lit3", gv(3), 100);
    session(2, 0, 0, 0, 0, 0, 0);
    chk("clr_lit0", gv(0), 19); chk("clr_lit3", gv(3), 50);

    // Saturation: 4*32767^2 = 0xFFFC0004
    for (int i = 0; i < 16; i++) begin
      a_v[i] = 32767;
      b_v[i] = 32767;
    end
    session(4, 0, 1, 0, 0, 0, 0);
    chk("sat_lit0", gv(0), 32767); chk("sat_lit15", gv(15), 32767);
    session(4, 0, 0, 0, 0, 0, 0);
    chk("trunc_lit0", gv(0), 4); chk("trunc_lit15", gv(15), 4);

    // Backpressure on both sides, mixed-sign 3x3, then the S=2 case gapped
    a_v[0] = 1;  a_v[1] = -2; a_v[2] = 3; a_v[3] = 4; a_v[4] = 5;
    a_v[5] = -6; a_v[6] = -7; a_v[7] = 8; a_v[8] = 9;
    b_v[0] = 2;  b_v[1] = 0;  b_v[2] = -1; b_v[3] = 3; b_v[4] = 1;
    b_v[5] = 4;  b_v[6] = -5; b_v[7] = 2;  b_v[8] = 7;
    session(3, 0, 0, 1, 1, 0, 0);
    chk("bp3_lit0", gv(0), -19);
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    session(2, 0, 0, 1, 1, 0, 0);
    chk("bp2_lit0", gv(0), 19); chk("bp2_lit1", gv(1), 22);
    chk("bp2_lit2", gv(2), 43); chk("bp2_lit3", gv(3), 50);

    // Reset mid-CALC clears C, so an accumulate session yields the plain product
    session(2, 1, 0, 0, 0, 1, 0);
    session(2, 1, 0, 0, 0, 0, 0);
    chk("post_rst_lit0", gv(0), 19); chk("post_rst_lit3", gv(3), 50);

    // start during OUT is ignored
    for (int i = 0; i < 16; i++) begin
      a_v[i] = (i / 4 == i % 4) ? 1 : 0;
      b_v[i] = i + 1;
    end
    session(4, 0, 0, 0, 0, 0, 1);
    chk("sio_lit15", gv(15), 16);
    repeat (4) @(negedge clk);
    chk("sio_still_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
